// File: rtl/dmem_copy_engine_pkg.sv
// -----------------------------------------------------------------------------
// dmem_copy_engine_pkg
//   Shared definitions for the data-memory copy/fill engine: FSM state
//   encoding, transfer mode constants and the default memory geometry that
//   the engine shares with the data memory it drives.
// -----------------------------------------------------------------------------
package dmem_copy_engine_pkg;

    // Default geometry, kept in step with the data memory.
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DEPTH_LOG2 = 8;

    // Transfer modes as sampled on the `mode` input.
    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

endpackage : dmem_copy_engine_pkg

// File: rtl/dmem_addr_gen.sv
// -----------------------------------------------------------------------------
// dmem_addr_gen
//   Address generator for the copy engine. Latches the source/destination
//   base word indices and the transfer length at load time, keeps the word
//   counter, and produces wrapped (modulo 2**DEPTH_LOG2) word addresses.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   load_i         capture bases/length and clear the counter
//   advance_i      increment the counter (one word written)
//   src_i, dst_i   base word indices (low DEPTH_LOG2 bits only)
//   len_i          transfer length, 1..2**DEPTH_LOG2 when used
//   dst_cur_o      dst + cnt        (address of the word being written now)
//   src_nxt_o      src + cnt + 1    (next read address after this write)
//   dst_nxt_o      dst + cnt + 1    (next write address after this write)
//   last_o         cnt + 1 == len   (the current write is the final one)
// -----------------------------------------------------------------------------
module dmem_addr_gen #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  advance_i,
    input  logic [DEPTH_LOG2-1:0] src_i,
    input  logic [DEPTH_LOG2-1:0] dst_i,
    input  logic [DEPTH_LOG2:0]   len_i,
    output logic [DEPTH_LOG2-1:0] dst_cur_o,
    output logic [DEPTH_LOG2-1:0] src_nxt_o,
    output logic [DEPTH_LOG2-1:0] dst_nxt_o,
    output logic                  last_o
);

    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [DEPTH_LOG2-1:0] src_q;
    logic [DEPTH_LOG2-1:0] dst_q;
    logic [CNT_W-1:0]      len_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_inc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            src_q <= src_i;
            dst_q <= dst_i;
            len_q <= len_i;
            cnt_q <= '0;
        end else if (advance_i) begin
            cnt_q <= cnt_inc;
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Truncating to DEPTH_LOG2 bits is the modulo wrap of the word index.
    assign dst_cur_o = dst_q + cnt_q[DEPTH_LOG2-1:0];
    assign src_nxt_o = src_q + cnt_inc[DEPTH_LOG2-1:0];
    assign dst_nxt_o = dst_q + cnt_inc[DEPTH_LOG2-1:0];
    assign last_o    = (cnt_inc == len_q);

endmodule : dmem_addr_gen

// File: rtl/dmem_copy_engine.sv
// -----------------------------------------------------------------------------
// dmem_copy_engine
//   Memory-port initiator that copies LEN words from SRC to DST (COPY) or
//   writes LEN copies of a pattern from DST upward (FILL). It owns the data
//   memory port while `busy` is high; an external mux hands the port back to
//   the CPU otherwise.
//
//   COPY alternates RD/WR per word; FILL stays in WR. The copy is strictly
//   ascending, so an overlapping dst > src replicates the leading words.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle request, sampled only in IDLE
//   mode            0 = COPY, 1 = FILL (latched at start)
//   src, dst        source / destination word addresses (latched at start)
//   len             word count 0..2**DEPTH_LOG2 (latched at start)
//   pattern         fill value (latched at start)
//   read_add        shared memory address (registered)
//   write_data      memory write data (registered)
//   MemRead         read strobe; read_data is valid in the same cycle
//   MemWrite        write strobe; memory writes on the rising edge
//   read_data       memory read data
//   busy            high while in RD or WR
//   done            one-cycle completion pulse
// -----------------------------------------------------------------------------
module dmem_copy_engine
    import dmem_copy_engine_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_W-1:0]     src,
    input  logic [ADDR_W-1:0]     dst,
    input  logic [DEPTH_LOG2:0]   len,
    input  logic [DATA_W-1:0]     pattern,
    output logic [ADDR_W-1:0]     read_add,
    output logic [DATA_W-1:0]     write_data,
    output logic                  MemRead,
    output logic                  MemWrite,
    input  logic [DATA_W-1:0]     read_data,
    output logic                  busy,
    output logic                  done
);

    state_e                state_q;
    logic                  mode_q;
    logic [DATA_W-1:0]     pattern_q;
    logic [ADDR_W-1:0]     read_add_q;
    logic [DATA_W-1:0]     write_data_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  ag_load;
    logic                  ag_advance;
    logic [DEPTH_LOG2-1:0] dst_cur;
    logic [DEPTH_LOG2-1:0] src_nxt;
    logic [DEPTH_LOG2-1:0] dst_nxt;
    logic                  last_word;

    // Only the low DEPTH_LOG2 address bits select a word; the rest wrap away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{src[ADDR_W-1:DEPTH_LOG2], dst[ADDR_W-1:DEPTH_LOG2]};

    // The counter advances on every WR edge, including the final one; the
    // value left behind is irrelevant because the next start reloads it.
    assign ag_load    = (state_q == ST_IDLE) && start;
    assign ag_advance = (state_q == ST_WR);

    dmem_addr_gen #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load_i    (ag_load),
        .advance_i (ag_advance),
        .src_i     (src[DEPTH_LOG2-1:0]),
        .dst_i     (dst[DEPTH_LOG2-1:0]),
        .len_i     (len),
        .dst_cur_o (dst_cur),
        .src_nxt_o (src_nxt),
        .dst_nxt_o (dst_nxt),
        .last_o    (last_word)
    );

    // Outputs are loaded on the edge that enters a state, so every strobe and
    // address is a plain flop output during the cycle it applies to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_COPY;
            pattern_q    <= '0;
            read_add_q   <= '0;
            write_data_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: strobes and done default low each cycle so only the state
            // being entered raises them; address/data keep their last value.
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        pattern_q <= pattern;
                        if (len == '0) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else if (mode == MODE_COPY) begin
                            state_q    <= ST_RD;
                            busy_q     <= 1'b1;
                            mem_read_q <= 1'b1;
                            read_add_q <= ADDR_W'(src[DEPTH_LOG2-1:0]);
                        end else begin
                            state_q      <= ST_WR;
                            busy_q       <= 1'b1;
                            mem_write_q  <= 1'b1;
                            read_add_q   <= ADDR_W'(dst[DEPTH_LOG2-1:0]);
                            write_data_q <= pattern;
                        end
                    end
                end

                ST_RD: begin
                    // The memory answers combinationally, so the word is
                    // captured straight into the write-data register.
                    state_q      <= ST_WR;
                    mem_write_q  <= 1'b1;
                    read_add_q   <= ADDR_W'(dst_cur);
                    write_data_q <= read_data;
                end

                ST_WR: begin
                    if (last_word) begin
                        state_q <= ST_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (mode_q == MODE_COPY) begin
                        state_q    <= ST_RD;
                        mem_read_q <= 1'b1;
                        read_add_q <= ADDR_W'(src_nxt);
                    end else begin
                        state_q      <= ST_WR;
                        mem_write_q  <= 1'b1;
                        read_add_q   <= ADDR_W'(dst_nxt);
                        write_data_q <= pattern_q;
                    end
                end

                ST_FIN: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign read_add   = read_add_q;
    assign write_data = write_data_q;
    assign MemRead    = mem_read_q;
    assign MemWrite   = mem_write_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule : dmem_copy_engine
